// File: rtl/axi3_hp_writer.sv
// AXI3 HP-port burst writer: one fixed-length INCR burst per DMA_START, W data passed straight through.
// Optional write-response error flag enabled by defining AXI3_HP_WRITER_BRESP_CHECK_EN.
//
// state | meaning
// IDLE  | waiting for DMA_START, DMA_READY high
// ADDR  | AW channel valid, waiting for awready
// DATA  | W channel open to the producer, counting beats
// RESP  | bready high, waiting for the write response
module axi3_hp_writer #(
    parameter int BURST_SIZE = 8
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [29:0] DMA_WR_ADDR,
    input  logic        DMA_START,
    output logic        DMA_READY,
    input  logic [31:0] DMA_WR_DATA,
    input  logic        DMA_WR_DATA_VALID,
    output logic        DMA_WR_DATA_READY,
    output logic        DMA_DONE,
    output logic        DMA_ERROR,
    input  logic        m00_axi_awready,
    output logic [31:0] m00_axi_awaddr,
    output logic [3:0]  m00_axi_awlen,
    output logic [2:0]  m00_axi_awsize,
    output logic [1:0]  m00_axi_awburst,
    output logic        m00_axi_awvalid,
    input  logic        m00_axi_wready,
    output logic [31:0] m00_axi_wdata,
    output logic [3:0]  m00_axi_wstrb,
    output logic        m00_axi_wlast,
    output logic        m00_axi_wvalid,
    input  logic        m00_axi_bvalid,
    input  logic [1:0]  m00_axi_bresp,
    output logic        m00_axi_bready
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

    localparam logic [3:0] LAST_BEAT = 4'(BURST_SIZE - 1);

    state_t      state_q;
    logic [31:0] awaddr_q;
    logic [3:0]  beat_q;
    logic [3:0]  beat_d;
    logic        done_q;
    logic        in_data;
    logic        w_hs;

    assign in_data = (state_q == DATA);
    assign beat_d  = beat_q + 4'd1;

    // W channel is a zero-latency pass-through gated by the DATA state
    assign m00_axi_wvalid    = in_data & DMA_WR_DATA_VALID;
    assign m00_axi_wdata     = in_data ? DMA_WR_DATA : 32'd0;
    assign DMA_WR_DATA_READY = in_data & m00_axi_wready;
    assign m00_axi_wlast     = in_data & (beat_q == LAST_BEAT);
    assign w_hs              = m00_axi_wvalid & m00_axi_wready;

    assign m00_axi_awlen   = LAST_BEAT;
    assign m00_axi_awsize  = 3'b010;
    assign m00_axi_awburst = 2'b01;
    assign m00_axi_wstrb   = 4'b1111;
    assign m00_axi_awaddr  = awaddr_q;
    assign m00_axi_awvalid = (state_q == ADDR);
    assign m00_axi_bready  = (state_q == RESP);
    assign DMA_READY       = (state_q == IDLE);
    assign DMA_DONE        = done_q;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q  <= IDLE;
            awaddr_q <= 32'd0;
            beat_q   <= 4'd0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (DMA_START) begin
                        awaddr_q <= {DMA_WR_ADDR, 2'b00};
                        state_q  <= ADDR;
                    end
                end
                ADDR: begin
                    if (m00_axi_awready) begin
                        beat_q  <= 4'd0;
                        state_q <= DATA;
                    end
                end
                DATA: begin
                    if (w_hs) begin
                        beat_q <= beat_d;
                        if (m00_axi_wlast) begin
                            state_q <= RESP;
                        end
                    end
                end
                RESP: begin
                    if (m00_axi_bvalid) begin
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef AXI3_HP_WRITER_BRESP_CHECK_EN
    logic error_q;

    // Sticky until reset or the next accepted burst request
    always_ff @(posedge CLK) begin
        if (RESET) begin
            error_q <= 1'b0;
        end else if ((state_q == IDLE) && DMA_START) begin
            error_q <= 1'b0;
        end else if ((state_q == RESP) && m00_axi_bvalid && (m00_axi_bresp != 2'b00)) begin
            error_q <= 1'b1;
        end
    end

    assign DMA_ERROR = error_q;
`else
    logic unused_bresp;

    assign unused_bresp = ^m00_axi_bresp;
    assign DMA_ERROR    = 1'b0;
`endif

endmodule

// File: tb/tb_axi3_hp_writer.sv
// Self-checking bench for axi3_hp_writer: randomized bursts against a protocol-level phase model.
module tb_axi3_hp_writer;

`ifdef AXI3_HP_WRITER_BRESP_CHECK_EN
    localparam bit BRESP_EN = 1'b1;
`else
    localparam bit BRESP_EN = 1'b0;
`endif
    localparam int NB = 8;

    logic CLK = 1'b0;
    logic RESET;
    always #5 CLK = ~CLK;

    logic [29:0] dma_addr;
    logic        dma_start, dma_ready, wr_valid, wr_ready, done, err;
    logic [31:0] wr_data;
    logic        awready, awvalid, wready, wlast, wvalid, bvalid, bready;
    logic [31:0] awaddr, wdata;
    logic [3:0]  awlen, wstrb;
    logic [2:0]  awsize;
    logic [1:0]  awburst, bresp;

    logic [29:0] s_addr;
    logic        s_start, s_ready, s_valid, s_wr_ready, s_done, s_err;
    logic [31:0] s_data;
    logic        s_awready, s_awvalid, s_wready, s_wlast, s_wvalid, s_bvalid, s_bready;
    logic [31:0] s_awaddr, s_wdata;
    logic [3:0]  s_awlen, s_wstrb;
    logic [2:0]  s_awsize;
    logic [1:0]  s_awburst, s_bresp;

    int checks = 0;
    int errors = 0;
    bit err_model = 1'b0;

    axi3_hp_writer #(.BURST_SIZE(NB)) dut (
        .CLK(CLK), .RESET(RESET), .DMA_WR_ADDR(dma_addr), .DMA_START(dma_start),
        .DMA_READY(dma_ready), .DMA_WR_DATA(wr_data), .DMA_WR_DATA_VALID(wr_valid),
        .DMA_WR_DATA_READY(wr_ready), .DMA_DONE(done), .DMA_ERROR(err),
        .m00_axi_awready(awready), .m00_axi_awaddr(awaddr), .m00_axi_awlen(awlen),
        .m00_axi_awsize(awsize), .m00_axi_awburst(awburst), .m00_axi_awvalid(awvalid),
        .m00_axi_wready(wready), .m00_axi_wdata(wdata), .m00_axi_wstrb(wstrb),
        .m00_axi_wlast(wlast), .m00_axi_wvalid(wvalid),
        .m00_axi_bvalid(bvalid), .m00_axi_bresp(bresp), .m00_axi_bready(bready)
    );

    axi3_hp_writer #(.BURST_SIZE(1)) dut1 (
        .CLK(CLK), .RESET(RESET), .DMA_WR_ADDR(s_addr), .DMA_START(s_start),
        .DMA_READY(s_ready), .DMA_WR_DATA(s_data), .DMA_WR_DATA_VALID(s_valid),
        .DMA_WR_DATA_READY(s_wr_ready), .DMA_DONE(s_done), .DMA_ERROR(s_err),
        .m00_axi_awready(s_awready), .m00_axi_awaddr(s_awaddr), .m00_axi_awlen(s_awlen),
        .m00_axi_awsize(s_awsize), .m00_axi_awburst(s_awburst), .m00_axi_awvalid(s_awvalid),
        .m00_axi_wready(s_wready), .m00_axi_wdata(s_wdata), .m00_axi_wstrb(s_wstrb),
        .m00_axi_wlast(s_wlast), .m00_axi_wvalid(s_wvalid),
        .m00_axi_bvalid(s_bvalid), .m00_axi_bresp(s_bresp), .m00_axi_bready(s_bready)
    );

    // Phases: 0 start cycle, 1 address, 2 data, 3 response, 4 done cycle
    task automatic run_burst(input logic [29:0] addr, input int aw_wait, input int wmode,
                             input logic [1:0] resp, input int rst_after, input bit stray, input bit seq);
        logic [31:0] data [16];
        int idx, phase, aw_seen, b_seen, cyc;
        bit hs, err_exp;
        err_exp = BRESP_EN && (resp != 2'b00);
        for (int i = 0; i < 16; i++) data[i] = seq ? 32'(i + 1) : $urandom;
        idx = 0; phase = 0; aw_seen = 0; b_seen = 0;
        for (cyc = 0; cyc < 400; cyc++) begin
            @(negedge CLK);
            if (rst_after > 0 && phase == 2 && idx == rst_after) begin
                RESET = 1'b1; dma_start = 1'b0; wr_valid = 1'b1; wready = 1'b1;
                @(posedge CLK); #1;
                checks++;
                if ({dma_ready, awvalid, wvalid, bready, done, err} !== 6'b100000) begin
                    errors++; $display("FAIL mid_reset_outputs got rdy/awv/wv/brdy/done/err=%b want 100000",
                                       {dma_ready, awvalid, wvalid, bready, done, err});
                end
                checks++;
                if (awaddr !== 32'd0) begin
                    errors++; $display("FAIL mid_reset_awaddr got %h want 0", awaddr);
                end
                @(negedge CLK); RESET = 1'b0; err_model = 1'b0;
                return;
            end
            dma_start = (phase == 0);
            dma_addr  = (phase == 0) ? addr : 30'($urandom);
            if (stray && phase == 2 && idx == 2) begin
                dma_start = 1'b1; dma_addr = addr ^ 30'h155;
            end
            wr_valid = (wmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            wr_data  = (idx < NB) ? data[idx] : $urandom;
            wready   = (wmode == 0) ? 1'b1 : (wmode == 1) ? cyc[0] : 1'($urandom_range(0, 1));
            awready  = (phase == 1) && (aw_seen >= aw_wait);
            bvalid   = (phase == 3) && (b_seen >= 1);
            bresp    = (phase == 3) ? resp : 2'($urandom);
            #1;
            hs = (phase == 2) && wr_valid && wready;
            checks++;
            if ({awvalid, bready, dma_ready, done} !== {phase == 1, phase == 3, phase == 0 || phase == 4, phase == 4}) begin
                errors++; $display("FAIL ctrl phase=%0d got awv/brdy/rdy/done=%b%b%b%b", phase, awvalid, bready, dma_ready, done);
            end
            checks++;
            if ({wvalid, wr_ready} !== {phase == 2 && wr_valid, phase == 2 && wready}) begin
                errors++; $display("FAIL w_gate phase=%0d got wvalid=%b wr_ready=%b", phase, wvalid, wr_ready);
            end
            if (phase == 0) begin
                checks++;
                if (err !== err_model) begin
                    errors++; $display("FAIL err_before got %b want %b", err, err_model);
                end
            end else begin
                checks++;
                if (err !== (phase == 4 ? err_exp : 1'b0)) begin
                    errors++; $display("FAIL err phase=%0d got %b want %b", phase, err, phase == 4 ? err_exp : 1'b0);
                end
            end
            if (phase == 1) begin
                checks++;
                if ({awaddr, awlen, awsize, awburst} !== {addr, 2'b00, 4'(NB - 1), 3'b010, 2'b01}) begin
                    errors++; $display("FAIL aw got addr=%h len=%0d size=%0d burst=%0d want addr=%h", awaddr, awlen, awsize, awburst, {addr, 2'b00});
                end
            end
            if (hs) begin
                checks++;
                if ({wdata, wlast, wstrb} !== {data[idx], idx == NB - 1, 4'hF}) begin
                    errors++; $display("FAIL beat%0d got data=%h last=%b strb=%h want data=%h last=%b", idx, wdata, wlast, wstrb, data[idx], idx == NB - 1);
                end
            end
            case (phase)
                0: phase = 1;
                1: begin if (awready) phase = 2; aw_seen++; end
                2: if (hs) begin idx++; if (idx == NB) phase = 3; end
                3: begin if (bvalid) phase = 4; b_seen++; end
                default: break;
            endcase
        end
        checks++;
        if (cyc >= 400) begin
            errors++; $display("FAIL burst_timeout phase=%0d want completion", phase);
        end
        err_model = err_exp;
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK); dma_start = 1'b0; bvalid = 1'b0; awready = 1'b0; #1;
            checks++;
            if ({awvalid, dma_ready, done, err} !== {3'b010, err_model}) begin
                errors++; $display("FAIL idle_after got awv/rdy/done/err=%b want 010%b", {awvalid, dma_ready, done, err}, err_model);
            end
        end
    endtask

    task automatic test_reset();
        RESET = 1'b1; dma_start = 1'b1; wr_valid = 1'b1; wready = 1'b1; awready = 1'b1; bvalid = 1'b1;
        s_start = 1'b1; s_valid = 1'b1; s_wready = 1'b1; s_awready = 1'b1; s_bvalid = 1'b1;
        repeat (3) @(negedge CLK);
        #1;
        checks++;
        if ({dma_ready, awvalid, wvalid, wr_ready, bready, done, err} !== 7'b1000000) begin
            errors++; $display("FAIL reset_ctrl got %b want 1000000", {dma_ready, awvalid, wvalid, wr_ready, bready, done, err});
        end
        checks++;
        if ({awaddr, wdata} !== 64'd0) begin
            errors++; $display("FAIL reset_zero got awaddr=%h wdata=%h want 0", awaddr, wdata);
        end
        checks++;
        if ({awlen, awsize, awburst, wstrb} !== {4'd7, 3'b010, 2'b01, 4'hF}) begin
            errors++; $display("FAIL reset_const got len=%0d size=%0d burst=%0d strb=%h", awlen, awsize, awburst, wstrb);
        end
        checks++;
        if ({s_ready, s_awvalid, s_wvalid, s_bready, s_done} !== 5'b10000) begin
            errors++; $display("FAIL reset_dut1 got %b want 10000", {s_ready, s_awvalid, s_wvalid, s_bready, s_done});
        end
        dma_start = 1'b0; s_start = 1'b0; bvalid = 1'b0; awready = 1'b0;
        RESET = 1'b0;
        @(negedge CLK); #1;
        checks++;
        if ({dma_ready, wvalid, wr_ready} !== 3'b100) begin
            errors++; $display("FAIL idle_w_gate got rdy/wv/wrdy=%b want 100", {dma_ready, wvalid, wr_ready});
        end
    endtask

    task automatic test_basic();
        run_burst(30'h100, 3, 0, 2'b00, 0, 1'b0, 1'b1);
    endtask

    task automatic test_wready_toggle();
        for (int i = 0; i < 3; i++) run_burst(30'($urandom), i, 1, 2'b00, 0, 1'b0, 1'b0);
    endtask

    task automatic test_stray_start();
        run_burst(30'h2A5, 1, 2, 2'b00, 0, 1'b1, 1'b0);
        run_burst(30'h3FFF_FFFF, 0, 0, 2'b00, 0, 1'b0, 1'b0);
    endtask

    task automatic test_error();
        run_burst(30'h40, 0, 0, 2'b10, 0, 1'b0, 1'b0);
        run_burst(30'h80, 2, 2, 2'b00, 0, 1'b0, 1'b0);
        run_burst(30'hC0, 1, 0, 2'b11, 0, 1'b0, 1'b0);
        @(negedge CLK); RESET = 1'b1;
        @(negedge CLK); #1;
        checks++;
        if ({err, dma_ready} !== 2'b01) begin
            errors++; $display("FAIL err_reset got err=%b rdy=%b want 0 1", err, dma_ready);
        end
        RESET = 1'b0; err_model = 1'b0;
    endtask

    task automatic test_reset_mid_burst();
        run_burst(30'h1234, 1, 0, 2'b00, 3, 1'b0, 1'b0);
        run_burst(30'h5678, 2, 2, 2'b00, 0, 1'b0, 1'b1);
    endtask

    task automatic test_burst1();
        logic [31:0] d;
        d = $urandom;
        s_awready = 1'b1; s_wready = 1'b1; s_valid = 1'b1; s_bvalid = 1'b1; s_bresp = 2'b00; s_data = d;
        @(negedge CLK); s_start = 1'b1; s_addr = 30'h77; #1;
        checks++;
        if ({s_ready, s_awvalid} !== 2'b10) begin
            errors++; $display("FAIL b1_idle got rdy=%b awv=%b", s_ready, s_awvalid);
        end
        @(negedge CLK); s_start = 1'b0; s_addr = 30'h0; #1;
        checks++;
        if ({s_awvalid, s_awlen, s_awaddr} !== {1'b1, 4'd0, 32'h1DC}) begin
            errors++; $display("FAIL b1_addr got awv=%b len=%0d addr=%h want 1 0 1dc", s_awvalid, s_awlen, s_awaddr);
        end
        @(negedge CLK); #1;
        checks++;
        if ({s_wvalid, s_wlast, s_wdata} !== {2'b11, d}) begin
            errors++; $display("FAIL b1_beat got wv=%b last=%b data=%h want 1 1 %h", s_wvalid, s_wlast, s_wdata, d);
        end
        @(negedge CLK); #1;
        checks++;
        if ({s_bready, s_wvalid, s_wr_ready} !== 3'b100) begin
            errors++; $display("FAIL b1_resp got brdy=%b wv=%b wrdy=%b want 1 0 0", s_bready, s_wvalid, s_wr_ready);
        end
        @(negedge CLK); #1;
        checks++;
        if ({s_done, s_ready, s_err} !== 3'b110) begin
            errors++; $display("FAIL b1_done got done=%b rdy=%b err=%b want 1 1 0", s_done, s_ready, s_err);
        end
        s_bvalid = 1'b0;
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++)
            run_burst(30'($urandom), $urandom_range(0, 4), 2, 2'($urandom), 0, 1'b0, 1'b0);
    endtask

    initial begin
        dma_addr = '0; dma_start = 1'b0; wr_data = '0; wr_valid = 1'b0;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
        s_addr = '0; s_start = 1'b0; s_data = '0; s_valid = 1'b0;
        s_awready = 1'b0; s_wready = 1'b0; s_bvalid = 1'b0; s_bresp = 2'b00;
        test_reset();
        test_basic();
        test_wready_toggle();
        test_stray_start();
        test_error();
        test_reset_mid_burst();
        test_burst1();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
